// File: rtl/keypad_arb_pkg.sv
// Shared constants and FSM encodings for the keypad arbiter and its key buffer.
package keypad_arb_pkg;

    localparam int unsigned KEY_W     = 4;
    localparam int unsigned N_CLIENTS = 2;

    // Grant FSM
    localparam logic [1:0] G_IDLE = 2'd0;
    localparam logic [1:0] G_OWN0 = 2'd1;
    localparam logic [1:0] G_OWN1 = 2'd2;

    // Keyboard handshake FSM
    localparam logic K_IDLE = 1'b0;
    localparam logic K_ACK  = 1'b1;

endpackage

// File: rtl/key_fifo.sv
// Small synchronous FIFO holding captured key indices; flush wins over push/pop.
module key_fifo
    import keypad_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [KEY_W-1:0]         data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [KEY_W-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [KEY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + AW'(1);
            if (do_pop)  rd_d = rd_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is reset so the shared key_code output reads 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/keypad_arbiter.sv
// Round-robin owner of the shared keypad scanner; acks its handshake and streams keys to the owner.
module keypad_arbiter
    import keypad_arb_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CLIENTS-1:0] req,
    output logic [N_CLIENTS-1:0] gnt,
    output logic [N_CLIENTS-1:0] key_valid,
    input  logic [N_CLIENTS-1:0] key_ready,
    output logic [KEY_W-1:0]     key_code,
    output logic                 kb_en,
    input  logic                 kb_key_valid,
    output logic                 kb_key_received,
    input  logic [KEY_W-1:0]     kb_pressed_index
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]       g_q, g_d;
    logic             last_q, last_d;
    logic             k_q, k_d;
    logic             flush, push, pop, owner_req;
    logic             fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    always_comb begin
        g_d    = g_q;
        last_d = last_q;
        flush  = 1'b0;
        case (g_q)
            G_IDLE: begin
                if (req[0] && req[1]) g_d = last_q ? G_OWN0 : G_OWN1;
                else if (req[0])      g_d = G_OWN0;
                else if (req[1])      g_d = G_OWN1;
            end
            G_OWN0: begin
                if (!req[0]) begin
                    g_d    = G_IDLE;
                    flush  = 1'b1;
                    last_d = 1'b0;
                end
            end
            G_OWN1: begin
                if (!req[1]) begin
                    g_d    = G_IDLE;
                    flush  = 1'b1;
                    last_d = 1'b1;
                end
            end
            default: g_d = G_IDLE;
        endcase
    end

    assign gnt       = {g_q == G_OWN1, g_q == G_OWN0};
    assign kb_en     = |gnt;
    assign owner_req = |(gnt & req);

    // A full buffer leaves the keyboard stalled with valid high, so no key is dropped.
    always_comb begin
        k_d  = k_q;
        push = 1'b0;
        case (k_q)
            K_IDLE: begin
                if (kb_key_valid && owner_req && !fifo_full) begin
                    k_d  = K_ACK;
                    push = 1'b1;
                end
            end
            K_ACK:   if (!kb_key_valid) k_d = K_IDLE;
            default: k_d = K_IDLE;
        endcase
    end

    assign kb_key_received = (k_q == K_ACK);
    assign key_valid       = gnt & {N_CLIENTS{!fifo_empty}};
    assign pop             = |(key_valid & key_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_q    <= G_IDLE;
            last_q <= 1'b1;
            k_q    <= K_IDLE;
        end else begin
            g_q    <= g_d;
            last_q <= last_d;
            k_q    <= k_d;
        end
    end

    key_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (kb_pressed_index),
        .pop_i   (pop),
        .flush_i (flush),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (key_code),
        .count_o (fifo_count)
    );

    full_matches_count: assert property (
        @(posedge clk) disable iff (!rst_n) fifo_full == (fifo_count == CNT_W'(FIFO_DEPTH))
    );

endmodule

// File: tb/tb_keypad_arbiter.sv
// Directed bench for keypad_arbiter: keyboard handshake model plus a key scoreboard.
module tb_keypad_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] gnt;
    logic [1:0] key_valid;
    logic [1:0] key_ready = 2'b00;
    logic [3:0] key_code;
    logic       kb_en;
    logic       kb_key_valid = 1'b0;
    logic       kb_key_received;
    logic [3:0] kb_pressed_index = 4'h0;

    int n_checks = 0;
    int n_pass = 0;
    logic [3:0] exp_q[$];

    keypad_arbiter #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req              (req),
        .gnt              (gnt),
        .key_valid        (key_valid),
        .key_ready        (key_ready),
        .key_code         (key_code),
        .kb_en            (kb_en),
        .kb_key_valid     (kb_key_valid),
        .kb_key_received  (kb_key_received),
        .kb_pressed_index (kb_pressed_index)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Keyboard model: present a key, wait for the ack, then complete the 4-phase handshake.
    task automatic kb_press(input logic [3:0] k);
        kb_pressed_index = k;
        kb_key_valid = 1'b1;
        exp_q.push_back(k);
        for (int i = 0; i < 20; i++) begin
            step();
            if (kb_key_received) break;
        end
        check("kb_ack", {7'd0, kb_key_received}, 8'd1);
        kb_key_valid = 1'b0;
        step();
        check("kb_ack_release", {7'd0, kb_key_received}, 8'd0);
    endtask

    task automatic drain_one(input int c);
        logic [3:0] e;
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (key_valid[c]) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("drain_valid", {7'd0, seen}, 8'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        check("key_code", {4'd0, key_code}, {4'd0, e});
        check("key_valid_other", {7'd0, key_valid[1-c]}, 8'd0);
        key_ready[c] = 1'b1;
        step();
        key_ready[c] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", {6'd0, gnt}, 8'd0);
        check("rst_key_valid", {6'd0, key_valid}, 8'd0);
        check("rst_key_code", {4'd0, key_code}, 8'd0);
        check("rst_kb_en", {7'd0, kb_en}, 8'd0);
        check("rst_kb_ack", {7'd0, kb_key_received}, 8'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single owner, key 0xE consumed immediately
        req = 2'b01;
        step();
        check("single_gnt", {6'd0, gnt}, 8'h01);
        check("single_kb_en", {7'd0, kb_en}, 8'd1);
        key_ready = 2'b01;
        kb_pressed_index = 4'hE;
        kb_key_valid = 1'b1;
        exp_q.push_back(4'hE);
        step();
        check("single_ack", {7'd0, kb_key_received}, 8'd1);
        check("single_key_valid", {6'd0, key_valid}, 8'h01);
        check("single_key_code", {4'd0, key_code}, {4'd0, exp_q.pop_front()});
        kb_key_valid = 1'b0;
        step();
        check("single_ack_drop", {7'd0, kb_key_received}, 8'd0);
        check("single_valid_once", {6'd0, key_valid}, 8'd0);
        key_ready = 2'b00;
        req = 2'b00;
        step();
        check("single_release_gnt", {6'd0, gnt}, 8'd0);
        check("single_release_en", {7'd0, kb_en}, 8'd0);

        // Reset asserted in the middle of K_ACK
        req = 2'b01;
        step();
        kb_pressed_index = 4'h9;
        kb_key_valid = 1'b1;
        step();
        check("midack_ack", {7'd0, kb_key_received}, 8'd1);
        req = 2'b00;
        rst_n = 1'b0;
        #1;
        check("midack_rst_ack", {7'd0, kb_key_received}, 8'd0);
        check("midack_rst_gnt", {6'd0, gnt}, 8'd0);
        check("midack_rst_valid", {6'd0, key_valid}, 8'd0);
        check("midack_rst_en", {7'd0, kb_en}, 8'd0);
        kb_key_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("midack_post_gnt", {6'd0, gnt}, 8'd0);
        check("midack_post_valid", {6'd0, key_valid}, 8'd0);

        // Tie and round-robin
        req = 2'b11;
        step();
        check("tie_first", {6'd0, gnt}, 8'h01);
        req = 2'b10;
        step();
        check("rr_idle0", {6'd0, gnt}, 8'h00);
        step();
        check("rr_gnt1", {6'd0, gnt}, 8'h02);
        req = 2'b11;
        step();
        check("rr_hold1", {6'd0, gnt}, 8'h02);
        req = 2'b01;
        step();
        check("rr_idle1", {6'd0, gnt}, 8'h00);
        step();
        check("rr_gnt0", {6'd0, gnt}, 8'h01);

        // Full FIFO backpressure (owner is client 0)
        kb_press(4'h0);
        kb_press(4'h1);
        kb_press(4'h2);
        kb_press(4'h3);
        check("full_key_valid", {6'd0, key_valid}, 8'h01);
        kb_pressed_index = 4'h4;
        kb_key_valid = 1'b1;
        exp_q.push_back(4'h4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("full_no_ack", {7'd0, kb_key_received}, 8'd0);
        end
        drain_one(0);
        for (int i = 0; i < 5; i++) begin
            if (kb_key_received) break;
            step();
        end
        check("full_ack_after_pop", {7'd0, kb_key_received}, 8'd1);
        kb_key_valid = 1'b0;
        step();
        drain_one(0);
        drain_one(0);
        drain_one(0);
        drain_one(0);
        check("full_drained", {6'd0, key_valid}, 8'd0);

        // Release with buffered keys
        req = 2'b00;
        step();
        req = 2'b10;
        step();
        check("buf_gnt1", {6'd0, gnt}, 8'h02);
        kb_press(4'hA);
        kb_press(4'hB);
        check("buf_valid1", {6'd0, key_valid}, 8'h02);
        req = 2'b01;
        step();
        exp_q.delete();
        check("buf_flush_gnt", {6'd0, gnt}, 8'h00);
        check("buf_flush_valid", {6'd0, key_valid}, 8'h00);
        step();
        check("buf_gnt0", {6'd0, gnt}, 8'h01);
        for (int i = 0; i < 3; i++) begin
            check("buf_no_stale", {6'd0, key_valid}, 8'h00);
            step();
        end
        kb_press(4'h7);
        drain_one(0);

        // Not enabled
        req = 2'b00;
        step();
        kb_pressed_index = 4'h5;
        kb_key_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("noen_kb_en", {7'd0, kb_en}, 8'd0);
            check("noen_ack", {7'd0, kb_key_received}, 8'd0);
            check("noen_valid", {6'd0, key_valid}, 8'd0);
        end
        kb_key_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_arbiter.md
# keypad_arbiter

Shares the single 4x4 keypad scanner (`keyboard`) between two client controllers, e.g. the menu/setup controller (client 0) and the in-game move controller (client 1). Grants the keypad round-robin to one requester at a time, drives the scanner's `en`, and completes its 4-phase `key_valid`/`key_received` handshake. Buffers captured key indices in a small FIFO and presents them to the owning client on a valid/ready stream.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, key buffer entries; power of two, >= 2.

Ports:
- `clk`  in  1  system clock; same clock as the keyboard module's `clk`.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  2  client ownership request, level; held high while owning.
- `gnt`  out  2  one-hot (or zero) ownership grant.
- `key_valid`  out  2  buffered key available to client i; only ever set for the granted client.
- `key_ready`  in  2  client i accepts the key presented this cycle.
- `key_code`  out  4  head-of-FIFO key index (0x0-0xF), shared by both clients.
- `kb_en`  out  1  to keyboard `en`.
- `kb_key_valid`  in  1  from keyboard `key_valid`.
- `kb_key_received`  out  1  to keyboard `key_received`.
- `kb_pressed_index`  in  4  from keyboard `pressed_index`.

## Operation
- Grant FSM states: G_IDLE, G_OWN0, G_OWN1.
  - G_IDLE: if `req` != 0, go to G_OWNi. If both bits are set, grant the client that did not hold the last grant. The last-grant pointer resets to 1, so client 0 wins the first tie.
  - G_OWNi: stay while `req[i]`=1. When `req[i]`=0, go to G_IDLE, flush the FIFO and update the last-grant pointer to i.
  - `gnt[i]` = (state==G_OWNi). `kb_en` = any G_OWN state.
- Keyboard handshake FSM states: K_IDLE, K_ACK.
  - K_IDLE to K_ACK when `kb_key_valid`=1, state is G_OWNi with `req[i]`=1, and the FIFO is not full.
  - On that transition, push `kb_pressed_index` and assert `kb_key_received`.
  - While the FIFO is full, the keyboard is not acknowledged. It stalls holding valid; no key is lost.
  - K_ACK: hold `kb_key_received`=1 until `kb_key_valid`=0, then return to K_IDLE with `kb_key_received`=0.
  - K_ACK always completes, even if the grant is released or `kb_en` drops mid-handshake.
- Client stream:
  - `key_valid[i]` = `gnt[i]` & FIFO not empty; `key_code` = FIFO head.
  - Pop when `key_valid[i]` & `key_ready[i]`.
  - Push and pop in the same cycle are both performed; the count is unchanged.
- Flush on release takes priority over a same-cycle push or pop. No push is possible that cycle anyway, because the capture condition requires `req[i]`=1.
- Width rules: the FIFO count is `$clog2(FIFO_DEPTH)+1` bits. Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `gnt`=0, `key_valid`=0, `key_code`=0, `kb_en`=0, `kb_key_received`=0; FIFO empty, G_IDLE, K_IDLE, last-grant=1.
- Grant latency: `req` sampled high in G_IDLE at edge n, so `gnt` and `kb_en` are high after edge n.
- Release: `req[i]` sampled low at edge n, so `gnt[i]` and `kb_en` are low after edge n, with the FIFO empty. The earliest regrant is after edge n+1, because the FSM passes through G_IDLE.
- Capture: `kb_key_valid` sampled high at edge n, so `kb_key_received`=1 and the key is in the FIFO after edge n. `key_valid[i]` is high in the same cycle (registered count).
- Ack release: `kb_key_valid` sampled low at edge m, so `kb_key_received`=0 after edge m.
- Throughput: at most one key per keyboard handshake. The minimum K_ACK dwell is 1 cycle.
- All inputs are synchronous to `clk`. `kb_*` signals come from the keyboard module, which already synchronizes from `scan_clk`.

## Structure
- `keypad_arb_pkg`: grant FSM enum, handshake FSM enum, `KEY_W`=4, `N_CLIENTS`=2.
- Sub-module `key_fifo`: parameterized FIFO_DEPTH x KEY_W with push, pop, flush, full, empty, head, and count.
- The arbiter and both FSMs live in `keypad_arbiter`.

## Test plan
- Reset mid-K_ACK: assert `rst_n`=0 while `kb_key_received`=1. All outputs go to 0 asynchronously; after reset release the block is in G_IDLE with the FIFO empty.
- Single owner:
  - Stimulus: `req`=01; press key 0xE; hold `key_ready[0]`=1.
  - Response: `kb_en`=1 one cycle after `req`. `kb_key_received` pulses until `kb_key_valid` falls. `key_valid[0]`=1 with `key_code`=0xE for exactly one cycle. `key_valid[1]` stays 0.
- Tie and round-robin:
  - Stimulus: `req`=11 from reset, then drop `req[0]`, then raise `req[0]` again.
  - Response: the first grant is 01. After the release the grant is 10, following one G_IDLE cycle. After `req[1]` drops with `req`=11, the grant is 01.
- Full FIFO backpressure:
  - Stimulus: FIFO_DEPTH=4, `key_ready`=0; press 0x0,0x1,0x2,0x3 then 0x4.
  - Response: the fifth `kb_key_valid` is not acknowledged. Popping once acknowledges 0x4. Subsequent pops yield 0x1,0x2,0x3,0x4 in order.
- Release with buffered keys:
  - Stimulus: owner 1 holds 2 keys (0xA, 0xB) unread, then drops `req[1]`; client 0 is then granted.
  - Response: FIFO flushed, and `key_valid[0]` stays 0 until a new press.
- Not enabled: `req`=00 while the keyboard would see a press of 0x5. Response: `kb_en`=0, `kb_key_received` never rises, and no `key_valid`.
